// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, status bit positions and FSM state encoding.
package uart_tx_mmio_pkg;

   localparam logic [31:0] TXDATA_OFF = 32'h0000_0008;
   localparam logic [31:0] STATUS_OFF = 32'h0000_000C;

   localparam int ST_BUSY  = 1;
   localparam int ST_FULL  = 2;
   localparam int ST_EMPTY = 3;
   localparam int ST_OVF   = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   function automatic logic [31:0] status_word(
      input logic busy,
      input logic full,
      input logic empty,
      input logic ovf
   );
      logic [31:0] w;
      w = '0;
      w[ST_BUSY]  = busy;
      w[ST_FULL]  = full;
      w[ST_EMPTY] = empty;
      w[ST_OVF]   = ovf;
      return w;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Pointers carry an extra wrap bit to tell full from empty.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp;
   logic [AW:0]      rp;
   logic             do_push;
   logic             do_pop;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);

   // A pop in the same cycle frees the slot a full push needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign rdata = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wp[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, status register,
// TX FIFO and the serialising state machine with its baud counter.
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int          CLK_FREQ   = 12000000,
   parameter int          BAUD       = 115200,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] IO_BASE    = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] mem_addr,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

   localparam logic [31:0] TX_ADDR = IO_BASE + TXDATA_OFF;
   localparam logic [31:0] ST_ADDR = IO_BASE + STATUS_OFF;

   logic          sel_tx;
   logic          sel_st;
   logic          push_req;
   logic          st_rd;
   logic          ovf_set;
   logic          overflow;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;
   logic          pop;

   tx_state_e     state;
   tx_state_e     state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [2:0]    idx;
   logic [2:0]    idx_n;
   logic [7:0]    shift;
   logic [7:0]    shift_n;
   logic          tx_d;
   logic          cnt_end;
   logic          unused_bits;

   assign unused_bits = ^{mem_wdata[31:8], mem_wmask[3:1],
                          mem_addr[1:0]};

   assign sel_tx   = (mem_addr[31:2] == TX_ADDR[31:2]);
   assign sel_st   = (mem_addr[31:2] == ST_ADDR[31:2]);
   assign push_req = sel_tx & mem_wmask[0];
   assign st_rd    = sel_st & mem_rstrb;
   assign ovf_set  = push_req & fifo_full & ~pop;

   assign tx_busy  = (state != S_IDLE) | ~fifo_empty;

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push_req),
      .wdata  (mem_wdata[7:0]),
      .pop    (pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Read data holds unless a known register is read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_rdata <= '0;
      end else if (mem_rstrb) begin
         unique case (1'b1)
            sel_st:  mem_rdata <= status_word(tx_busy, fifo_full,
                                              fifo_empty, overflow);
            sel_tx:  mem_rdata <= '0;
            default: ;
         endcase
      end
   end

   // A new overflow wins over the clear-on-read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         overflow <= 1'b0;
      else if (ovf_set)
         overflow <= 1'b1;
      else if (st_rd)
         overflow <= 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shift   <= shift_n;
         uart_tx <= tx_d;
      end
   end

   assign cnt_end = (cnt == CNT_LAST);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shift_n = shift;
      pop     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = fifo_rdata;
               cnt_n   = '0;
               state_n = S_START;
            end
         end
         S_START: begin
            if (cnt_end) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = S_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_end) begin
               cnt_n   = '0;
               shift_n = {1'b0, shift[7:1]};
               if (idx == 3'd7)
                  state_n = S_STOP;
               else
                  idx_n = idx + 3'd1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_end) begin
               cnt_n = '0;
               // Chain straight into the next start bit.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = fifo_rdata;
                  state_n = S_START;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Line level registered from the upcoming state.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_n)
         S_IDLE:  tx_d = 1'b1;
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_n[0];
         S_STOP:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: line decoder monitor plus
// a queue-based model of which bytes must appear on the line.
module tb_uart_tx_mmio;

   localparam int CPB = 16;
   localparam int FRAME = 10 * CPB;
   localparam logic [31:0] TXD = 32'h0040_0008;
   localparam logic [31:0] STS = 32'h0040_000C;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [31:0] mem_addr = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic        uart_tx;
   logic        tx_busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   int         ferr = 0;
   bit         mon_en = 1'b0;

   uart_tx_mmio #(
      .CLK_FREQ   (16),
      .BAUD       (1),
      .FIFO_DEPTH (4),
      .IO_BASE    (32'h0040_0000)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_addr  (mem_addr),
      .mem_rstrb (mem_rstrb),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: find a start bit, sample each bit mid-window.
   initial begin : monitor
      logic [7:0] b;
      int t0;
      bit ok;
      forever begin
         @(negedge clk);
         if (resetn && uart_tx === 1'b0) begin
            t0 = cyc;
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (uart_tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (uart_tx !== 1'b1) ok = 1'b0;
            if (mon_en) begin
               if (!ok) ferr++;
               rx_q.push_back(b);
               rx_t.push_back(t0);
            end
         end
      end
   end

   // Bus tasks are entered just after a falling edge.
   task automatic bus_write(input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [3:0] m);
      mem_addr  = a;
      mem_wdata = d;
      mem_wmask = m;
      @(negedge clk);
      mem_wmask = '0;
   endtask

   task automatic bus_read(input logic [31:0] a,
                           output logic [31:0] d);
      mem_addr  = a;
      mem_rstrb = 1'b1;
      @(negedge clk);
      mem_rstrb = 1'b0;
      d = mem_rdata;
   endtask

   task automatic wait_idle(input int budget,
                            output int drop, output bit ok);
      int n;
      n = 0;
      while (tx_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = !tx_busy;
      drop = cyc;
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_t.delete();
      ferr = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || mem_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_hold: tx=%b busy=%b rdata=%h want 1 0 0",
                  uart_tx, tx_busy, mem_rdata);
      end
      resetn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: tx=%b busy=%b want 1 0",
                  uart_tx, tx_busy);
      end
      bus_read(STS, d);
      n_cmp++;
      if (d !== 32'h8) begin
         n_bad++;
         $display("FAIL reset_status: got %h want %h", d, 32'h8);
      end
   endtask

   task automatic test_single(input logic [7:0] v);
      logic exp_tx;
      logic exp_busy;
      int seg;
      clear_rx();
      mon_en = 1'b1;
      bus_write(TXD, {$urandom_range(255, 0), v}, 4'b0001);
      n_cmp++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL single_k0: tx=%b busy=%b want 1 1",
                  uart_tx, tx_busy);
      end
      for (int k = 1; k <= FRAME + 1; k++) begin
         @(negedge clk);
         seg = (k - 1) / CPB;
         if (seg == 0)
            exp_tx = 1'b0;
         else if (seg <= 8)
            exp_tx = v[seg-1];
         else
            exp_tx = 1'b1;
         exp_busy = (k <= FRAME);
         n_cmp++;
         if (uart_tx !== exp_tx || tx_busy !== exp_busy) begin
            n_bad++;
            $display("FAIL single_wave k=%0d: tx=%b busy=%b want %b %b",
                     k, uart_tx, tx_busy, exp_tx, exp_busy);
         end
      end
      n_cmp++;
      if (rx_q.size() != 1 || ferr != 0 || rx_q[0] !== v) begin
         n_bad++;
         $display("FAIL single_rx: n=%0d ferr=%0d byte=%h want 1 0 %h",
                  rx_q.size(), ferr,
                  (rx_q.size() > 0) ? rx_q[0] : 8'hxx, v);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      int drop;
      bit ok;
      logic [7:0] exp[3];
      exp[0] = 8'h01;
      exp[1] = 8'h02;
      exp[2] = 8'h03;
      clear_rx();
      mon_en = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 3; i++)
         bus_write(TXD, {24'h0, exp[i]}, 4'b0001);
      wait_idle(3 * FRAME + 100, drop, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL b2b_timeout: busy=%b want 0", tx_busy);
      end
      n_cmp++;
      if (rx_q.size() != 3 || ferr != 0) begin
         n_bad++;
         $display("FAIL b2b_count: n=%0d ferr=%0d want 3 0",
                  rx_q.size(), ferr);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rx_q[i] !== exp[i] ||
                rx_t[i] != c0 + 2 + i * FRAME) begin
               n_bad++;
               $display("FAIL b2b_frame%0d: byte=%h t=%0d want %h %0d",
                        i, rx_q[i], rx_t[i], exp[i],
                        c0 + 2 + i * FRAME);
            end
         end
         n_cmp++;
         if (drop != rx_t[0] + 3 * FRAME) begin
            n_bad++;
            $display("FAIL b2b_busy_drop: at %0d want %0d",
                     drop, rx_t[0] + 3 * FRAME);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b[6];
      logic [31:0] d;
      int drop;
      bit ok;
      clear_rx();
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 5; i++)
         bus_write(TXD, {24'h0, b[i]}, 4'b0001);
      bus_read(STS, d);
      n_cmp++;
      if (d !== 32'h06) begin
         n_bad++;
         $display("FAIL ovf_full: got %h want %h", d, 32'h06);
      end
      bus_write(TXD, {24'h0, b[5]}, 4'b0001);
      bus_read(STS, d);
      n_cmp++;
      if (d !== 32'h16) begin
         n_bad++;
         $display("FAIL ovf_set: got %h want %h", d, 32'h16);
      end
      bus_read(STS, d);
      n_cmp++;
      if (d !== 32'h06) begin
         n_bad++;
         $display("FAIL ovf_clear: got %h want %h", d, 32'h06);
      end
      wait_idle(6 * FRAME + 100, drop, ok);
      n_cmp++;
      if (!ok || rx_q.size() != 5 || ferr != 0) begin
         n_bad++;
         $display("FAIL ovf_drain: ok=%b n=%0d ferr=%0d want 1 5 0",
                  ok, rx_q.size(), ferr);
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rx_q[i] !== b[i]) begin
               n_bad++;
               $display("FAIL ovf_byte%0d: got %h want %h",
                        i, rx_q[i], b[i]);
            end
         end
      end
   endtask

   task automatic test_mask_decode();
      logic [31:0] d;
      bus_read(STS, d);
      n_cmp++;
      if (d !== 32'h08) begin
         n_bad++;
         $display("FAIL dec_status: got %h want %h", d, 32'h08);
      end
      bus_write(TXD, 32'hA5A5_A5A5, 4'b1110);
      bus_write(STS, 32'hFFFF_FFFF, 4'b1111);
      bus_write(32'h0040_0000, 32'h0000_0033, 4'b0001);
      bus_write(TXD, 32'h0000_0044, 4'b0000);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
         n_bad++;
         $display("FAIL dec_nopush: busy=%b tx=%b want 0 1",
                  tx_busy, uart_tx);
      end
      bus_read(32'h0040_0004, d);
      n_cmp++;
      if (d !== 32'h08) begin
         n_bad++;
         $display("FAIL dec_hold: got %h want %h", d, 32'h08);
      end
      bus_read(TXD, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_bad++;
         $display("FAIL dec_txdata_rd: got %h want 0", d);
      end
      bus_read(32'h0040_0010, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_bad++;
         $display("FAIL dec_hold2: got %h want 0", d);
      end
   endtask

   // Firmware-style: poll for room, then store; model is a queue.
   task automatic test_random();
      logic [7:0]  exp_q[$];
      logic [31:0] d;
      logic [31:0] wd;
      logic [3:0]  m;
      int polls;
      int drop;
      bit ok;
      clear_rx();
      mon_en = 1'b1;
      for (int it = 0; it < 24; it++) begin
         polls = 0;
         bus_read(STS, d);
         while (d[2] && polls < 400) begin
            bus_read(STS, d);
            polls++;
         end
         n_cmp++;
         if (d[2] !== 1'b0 || d[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_poll: status=%h want full=0 ovf=0", d);
         end
         wd = $urandom;
         m  = 4'($urandom);
         bus_write(TXD | 32'($urandom_range(3, 0)), wd, m);
         if (m[0]) exp_q.push_back(wd[7:0]);
         repeat ($urandom_range(60, 0)) @(negedge clk);
      end
      wait_idle(30 * FRAME, drop, ok);
      n_cmp++;
      if (!ok || rx_q.size() != exp_q.size() || ferr != 0) begin
         n_bad++;
         $display("FAIL rnd_count: ok=%b n=%0d ferr=%0d want 1 %0d 0",
                  ok, rx_q.size(), ferr, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL rnd_byte%0d: got %h want %h",
                        i, rx_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_midframe_reset();
      logic [31:0] d;
      int lows;
      mon_en = 1'b0;
      bus_write(TXD, 32'h0000_0000, 4'b0001);
      bus_write(TXD, 32'h0000_005A, 4'b0001);
      repeat (70) @(negedge clk);
      n_cmp++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_bit3: tx=%b busy=%b want 0 1",
                  uart_tx, tx_busy);
      end
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_async: tx=%b busy=%b want 1 0",
                  uart_tx, tx_busy);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      lows = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      n_cmp++;
      if (lows != 0) begin
         n_bad++;
         $display("FAIL mid_residual: active cycles=%0d want 0", lows);
      end
      bus_read(STS, d);
      n_cmp++;
      if (d !== 32'h08) begin
         n_bad++;
         $display("FAIL mid_status: got %h want %h", d, 32'h08);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single(8'h55);
      test_single(8'($urandom));
      test_back_to_back();
      test_overflow();
      test_mask_decode();
      test_random();
      test_midframe_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, alongside the word-addressed RAM.
- Claims two word addresses in the IO page (IO_BASE = 0x0040_0000, the gp base used by firmware).
- Byte stores to the TX data register are queued in a small FIFO and serialised 8N1 on uart_tx.
- Firmware polls a status register to avoid overflowing the FIFO.

Parameters:
- CLK_FREQ, 12000000: core clock in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division truncated (104 at defaults); must be ≥ 2.
- FIFO_DEPTH, 4: TX FIFO entries; power of 2, ≥ 2.
- IO_BASE, 32'h0040_0000: IO page base address.

Ports:
- clk  in  1: core clock; all logic on the rising edge.
- resetn  in  1: asynchronous, active-low reset.
- mem_addr  in  32: byte address from the CPU.
- mem_rstrb  in  1: read strobe.
- mem_rdata  out  32: read data, registered.
- mem_wdata  in  32: write data.
- mem_wmask  in  4: byte write enables.
- uart_tx  out  1: serial line; idles high.
- tx_busy  out  1: high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Decode compares mem_addr[31:2] only.
  - TXDATA = IO_BASE+0x08.
  - STATUS = IO_BASE+0x0C.
  - Any other address: no effect, and mem_rdata holds its value.
- Write to TXDATA with mem_wmask[0]=1 pushes mem_wdata[7:0]. mem_wmask[3:1] are ignored. A write with mem_wmask[0]=0 does nothing.
- Push while full:
  - The byte is dropped and sticky overflow sets.
  - If a pop occurs in the same cycle, the push is accepted and there is no overflow.
- Read: mem_rstrb=1 at STATUS loads mem_rdata at the same edge, giving 1-cycle latency identical to RAM. mem_rdata = {27'b0, overflow, empty, full, tx_busy, 1'b0}:
  - bit1: tx_busy
  - bit2: full
  - bit3: empty
  - bit4: overflow
- Overflow clears on a STATUS read. If a read and a new overflow coincide, the read returns the old value and the flag ends set.
- Reads of TXDATA return 0. STATUS writes are ignored.
- FSM states: IDLE, START, DATA, STOP. One bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
  - IDLE: uart_tx=1. If FIFO is non-empty: pop into shift register, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: uart_tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. Shift right after each bit. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end:
    - FIFO non-empty: pop and go directly to START, with no idle bit.
    - Otherwise: go to IDLE.
- Frame = exactly 10*CLKS_PER_BIT cycles.
- Latency: write sampled at edge N into an empty FIFO in IDLE. Pop at edge N+1, and uart_tx is low from edge N+1.
- tx_busy = (state≠IDLE) | ~empty. uart_tx and mem_rdata are registered.
- Reset (async, any time, including mid-frame):
  - state=IDLE, uart_tx=1, FIFO empty, overflow=0, mem_rdata=0, counters=0.
  - A partial frame is abandoned. The line returns high immediately on resetn low.

Decomposition:
- Shared package holds:
  - register offsets TXDATA_OFF=0x08, STATUS_OFF=0x0C;
  - status bit positions;
  - FSM state encoding (2-bit).
- One sub-module: uart_fifo, a synchronous FIFO.
  - Parameters: WIDTH=8, DEPTH.
  - Ports: push/pop, full/empty.
  - Pointers one bit wider than log2(DEPTH) for full/empty detection.
  - Same-cycle push+pop allowed when full or non-empty.
- Top level: decode, FSM, baud counter, status register.

Test Plan (CLK_FREQ=16, BAUD=1, giving CLKS_PER_BIT=16, DEPTH=4):
- Reset: hold resetn=0 for 3 cycles, then release -> uart_tx=1, tx_busy=0, STATUS read returns 0x00000008.
- Single byte: SB 0x55 to 0x00400008 -> uart_tx low from next edge for 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, then high 16 cycles. tx_busy drops exactly 160 cycles after the pop.
- Back-to-back: write 0x01,0x02,0x03 on consecutive cycles -> three frames contiguous at 480 cycles total with no idle gap. Decoded bytes 01,02,03.
- Overflow: with the line busy, write 5 bytes.
  - First byte is popped.
  - FIFO holds 4, so status full=1.
  - 6th write sets overflow. STATUS read returns bit4=1, the next read returns bit4=0.
  - Bytes transmitted: the first 5 only.
- Mask/decode: SW with wmask=4'b1110 to TXDATA -> no push. Read of 0x00400004 -> mem_rdata unchanged. Read of TXDATA -> 0.
- Mid-frame reset: assert resetn during DATA bit 3 -> uart_tx=1 asynchronously. After release, FIFO is empty and no residual frame appears.
